// File: rtl/foo_pipe_arbiter_pkg.sv
// Shared types and constants for the foo_cycle1 pipeline arbiter.
package foo_arb_pkg;
    localparam int unsigned FOO_PIPE_LAT = 2;
    localparam int unsigned FOO_OPND_W   = 64;
    localparam int unsigned FOO_RES_W    = 32;
    // Wide enough for the largest supported requester count (16)
    localparam int unsigned FOO_ID_W     = 4;

    typedef struct packed {
        logic                valid;
        logic [FOO_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/foo_pipe_arbiter_if.sv
// Request/pipeline/response bundle between clients, the arbiter and foo_cycle1.
interface foo_pipe_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*64-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [63:0]           pipe_s;
    logic [31:0]           pipe_out;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;

    modport master (
        output req_valid, req_data, pipe_out,
        input  req_ready, pipe_s, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, pipe_out,
        output req_ready, pipe_s, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/foo_rr_arbiter.sv
// Combinational round-robin grant: first valid request searching upward from ptr+1.
module foo_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx   = (32'(ptr) + k) % N;
            idx_w = IDX_W'(idx);
            if (en && !found && req[idx_w]) begin
                found      = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_idx    = idx_w;
            end
        end
    end
endmodule

// File: rtl/foo_pipe_arbiter.sv
// Round-robin sharing of one foo_cycle1 adder pipeline with id-tagged responses.
// Optional per-requester grant counters under `FOO_PIPE_ARB_PERF_EN.
module foo_pipe_arbiter
    import foo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PIPE_LAT = FOO_PIPE_LAT,
    parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
`ifdef FOO_PIPE_ARB_PERF_EN
    input  logic                  cnt_clr,
    output logic [NUM_REQ*32-1:0] grant_cnt,
`endif
    foo_pipe_arbiter_if.slave     bus
);
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    tag_t               stage [PIPE_LAT];

    foo_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .en      (en),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The arbiter only grants valid requesters, so any grant is a transfer
    assign xfer          = |(gnt & bus.req_valid);
    assign bus.req_ready = gnt;

    always_comb begin
        bus.pipe_s = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) bus.pipe_s = bus.req_data[64*i +: 64];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (xfer) begin
            ptr <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{valid: xfer, id: FOO_ID_W'(gnt_idx)};
            for (int unsigned i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign bus.rsp_valid = stage[PIPE_LAT-1].valid;
    assign bus.rsp_id    = ID_W'(stage[PIPE_LAT-1].id);
    assign bus.rsp_data  = bus.pipe_out;

`ifdef FOO_PIPE_ARB_PERF_EN
    logic [31:0] cnt [NUM_REQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (cnt_clr) cnt[i] <= '0;
                else if (gnt[i] && bus.req_valid[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[32*i +: 32] = cnt[i];
    end
`endif
endmodule

// File: tb/tb_foo_pipe_arbiter.sv
// Self-checking bench for foo_pipe_arbiter with a behavioural foo_cycle1 stand-in.
module tb_foo_pipe_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    always #5 clk = ~clk;

    foo_pipe_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

`ifdef FOO_PIPE_ARB_PERF_EN
    logic            cnt_clr = 1'b0;
    logic [N*32-1:0] grant_cnt;
    logic [31:0]     mcnt [N];
`endif

    foo_pipe_arbiter #(.NUM_REQ(N), .PIPE_LAT(2), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
`ifdef FOO_PIPE_ARB_PERF_EN
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt),
`endif
        .bus   (bus)
    );

    // foo_cycle1 stand-in: two-cycle 32-bit wrap-around add of the operand halves
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= bus.pipe_s[63:32] + bus.pipe_s[31:0];
        p2 <= p1;
    end
    assign bus.pipe_out = p2;

    // Requester state and scoreboard of expected responses indexed by cycle
    bit          pend [N];
    logic [63:0] dat  [N];
    int          last;
    int          cyc;
    bit          ev [0:4095];
    int          eid [0:4095];
    logic [31:0] ed [0:4095];
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = pend[i];
            bus.req_data[64*i +: 64] = dat[i];
        end
    endtask

    task automatic cycle();
        int          w;
        logic [63:0] op;
        logic [N-1:0] er;
        apply();
        #1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev[cyc]));
        if (ev[cyc]) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(eid[cyc]));
            chk("rsp_data", 64'(bus.rsp_data), 64'(ed[cyc]));
        end
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && en && pend[(last + k) % N]) w = (last + k) % N;
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        op = (w >= 0) ? dat[w] : 64'h0;
        chk("pipe_s", bus.pipe_s, op);
        if (w >= 0) begin
            ev[cyc+2]  = 1'b1;
            eid[cyc+2] = w;
            ed[cyc+2]  = op[63:32] + op[31:0];
            last       = w;
        end
`ifdef FOO_PIPE_ARB_PERF_EN
        if (cnt_clr) begin
            for (int i = 0; i < N; i++) mcnt[i] = 32'd0;
        end else if (w >= 0 && mcnt[w] != 32'hFFFF_FFFF) begin
            mcnt[w] = mcnt[w] + 32'd1;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
        if (w >= 0) pend[w] = 1'b0;
`ifdef FOO_PIPE_ARB_PERF_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[32*i +: 32]), 64'(mcnt[i]));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = cyc; c < 4096; c++) ev[c] = 1'b0;
        last = N - 1;
`ifdef FOO_PIPE_ARB_PERF_EN
        for (int i = 0; i < N; i++) mcnt[i] = 32'd0;
`endif
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_rsp_valid_hold", 64'(bus.rsp_valid), 64'h0);
        rst_n = 1'b1;
    endtask

    task automatic fill_all();
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                pend[i] = 1'b1;
                dat[i]  = {$urandom, $urandom};
            end
        end
    endtask

    initial begin
        cyc  = 0;
        last = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            dat[i]  = 64'h0;
        end
        for (int c = 0; c < 4096; c++) begin
            ev[c]  = 1'b0;
            eid[c] = 0;
            ed[c]  = 32'h0;
        end
        apply();
        do_reset();

        // Idle after reset, then single request from req0
        cycle();
        en = 1'b1;
        pend[0] = 1'b1;
        dat[0]  = 64'h00000003_00000005;
        cycle();
        repeat (3) cycle();

        // Carry out of bit 31 is dropped
        pend[2] = 1'b1;
        dat[2]  = 64'hFFFFFFFF_00000001;
        repeat (4) cycle();

        // Full contention from reset: 0,1,2,3,0,...
        do_reset();
        repeat (10) begin
            fill_all();
            cycle();
        end

        // en gating with all valid, then resume
        en = 1'b0;
        repeat (3) begin
            fill_all();
            cycle();
        end
        en = 1'b1;
        repeat (5) begin
            fill_all();
            cycle();
        end

        // Reset with a tag in flight
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (3) cycle();
        pend[1] = 1'b1;
        dat[1]  = 64'h00000010_00000020;
        cycle();
        do_reset();
        pend[0] = 1'b1;
        dat[0]  = 64'h00000001_00000002;
        pend[1] = 1'b1;
        repeat (5) cycle();

`ifdef FOO_PIPE_ARB_PERF_EN
        do_reset();
        repeat (5) begin
            pend[3] = 1'b1;
            dat[3]  = {$urandom, $urandom};
            cycle();
        end
        chk("cnt3_before_clr", 64'(grant_cnt[3*32 +: 32]), 64'd5);
        pend[3] = 1'b1;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("cnt3_after_clr", 64'(grant_cnt[3*32 +: 32]), 64'd0);
        repeat (2) cycle();
`endif

        // Random traffic with random enable and one mid-run reset
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    dat[i]  = ($urandom_range(0, 7) == 0) ? 64'hFFFFFFFF_FFFFFFFF : {$urandom, $urandom};
                end
            end
`ifdef FOO_PIPE_ARB_PERF_EN
            cnt_clr = ($urandom_range(0, 31) == 0);
`endif
            if (n == 200) do_reset();
            else cycle();
        end
`ifdef FOO_PIPE_ARB_PERF_EN
        cnt_clr = 1'b0;
`endif
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
